// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register Tnew countdowns compared against source Tuse.
// stall/fire are combinational (zero latency); busy_mask and stall_cnt are registered state.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned ZERO_HW = 1,
  parameter int unsigned STAT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*ADDR_W-1:0]  src_addr,
  input  logic [NSRC*CNT_W-1:0]   src_tuse,
  input  logic                    dst_valid,
  input  logic [ADDR_W-1:0]       dst_addr,
  input  logic [CNT_W-1:0]        dst_tnew,
  input  logic                    flush,
  output logic                    stall,
  output logic                    fire,
  output logic [NREG-1:0]         busy_mask,
  output logic [STAT_W-1:0]       stall_cnt
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NSRC-1:0]  hazard;
  logic [NREG-1:0]  load;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  tuse;
    assign addr = src_addr[k*ADDR_W +: ADDR_W];
    assign tuse = src_tuse[k*CNT_W +: CNT_W];
    assign hazard[k] = issue_valid && src_valid[k] && (cnt[addr] > tuse) &&
                       !((ZERO_HW != 0) && (addr == '0));
  end

  assign stall = |hazard;
  assign fire  = issue_valid && !stall;

  // A new writer replaces any older countdown on the same register (WAW).
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign load[r] = fire && dst_valid && (dst_addr == ADDR_W'(r)) &&
                     !((ZERO_HW != 0) && (r == 0));
    assign busy_mask[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (load[r]) begin
          cnt[r] <= dst_tnew;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // The statistic still counts a stalled flush cycle; it saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
